gate_response_checker: RTL and testbench

Synthesizable response checker for 2-input logic gates, the consuming end of the gate stimulus flow. Accepts a stream of (a, b, y) observation vectors over a valid/ready handshake and compares each y against a parameterized 4-entry truth table. Tracks coverage of all four input combinations, counts mismatches and captures the first failing vector. Sits between a vector source (stimulus sequencer or sampled DUT pins) and status/LED or register readout.

---
 rtl/gate_check_pkg.sv | 24 ++
 rtl/sat_counter.sv | 33 +++
 rtl/gate_response_checker.sv | 108 ++++++++++
 tb/tb_gate_response_checker.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// +-----------------------------------------------------------------+
// | gate_check_pkg : shared types/constants for gate_response_checker|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package gate_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Truth tables indexed by {a,b}: bit0 = 00 ... bit3 = 11
    localparam logic [3:0] TT_NAND  = 4'b0111;
    localparam logic [3:0] TT_AND   = 4'b1000;
    localparam logic [3:0] TT_OR    = 4'b1110;
    localparam logic [3:0] TT_XOR   = 4'b0110;
    localparam logic [3:0] COV_FULL = 4'hF;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +-----------------------------------------------------------------+
// | sat_counter : up-counter with synchronous clear, holds at max   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/gate_response_checker.sv
// +-----------------------------------------------------------------+
// | gate_response_checker : checks (a,b,y) vectors vs truth table   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module gate_response_checker
    import gate_check_pkg::*;
#(
    parameter logic [3:0] TRUTH_TABLE = TT_NAND,
    parameter int         ERR_W       = 8,
    parameter int         VEC_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_y,
    output logic [3:0]       cov,
    output logic [ERR_W-1:0] err_cnt,
    output logic [VEC_W-1:0] vec_cnt,
    output logic             first_fail_vld,
    output logic [2:0]       first_fail,
    output logic             done,
    output logic             pass
);

    state_t     r_state;
    logic       r_ready;
    logic [3:0] r_cov;
    logic       r_ff_vld;
    logic [2:0] r_ff;
    logic       r_done;
    logic       r_pass;

    logic [1:0] w_idx;
    logic       w_xfer;
    logic       w_mismatch;
    logic [3:0] w_cov_next;

    assign w_idx      = {in_a, in_b};
    // A start in the same cycle as a handshake wins: the vector is dropped.
    assign w_xfer     = in_valid && (r_state == ST_RUN) && !start;
    assign w_mismatch = w_xfer && (in_y != TRUTH_TABLE[w_idx]);
    assign w_cov_next = r_cov | (4'b0001 << w_idx);

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .inc   (w_mismatch),
        .q     (err_cnt)
    );

    sat_counter #(.W(VEC_W)) u_vec_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .inc   (w_xfer),
        .q     (vec_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b0;
            r_cov    <= 4'h0;
            r_ff_vld <= 1'b0;
            r_ff     <= 3'b000;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else if (start) begin
            r_state  <= ST_RUN;
            r_ready  <= 1'b1;
            r_cov    <= 4'h0;
            r_ff_vld <= 1'b0;
            r_ff     <= 3'b000;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else if (w_xfer) begin
            r_cov <= w_cov_next;
            if (w_mismatch && !r_ff_vld) begin
                r_ff_vld <= 1'b1;
                r_ff     <= {in_a, in_b, in_y};
            end
            if (w_cov_next == COV_FULL) begin
                r_state <= ST_DONE;
                r_ready <= 1'b0;
                r_done  <= 1'b1;
                // err_cnt has not yet absorbed this vector's result
                r_pass  <= (err_cnt == '0) && !w_mismatch;
            end
        end
    end

    assign in_ready       = r_ready;
    assign cov            = r_cov;
    assign first_fail_vld = r_ff_vld;
    assign first_fail     = r_ff;
    assign done           = r_done;
    assign pass           = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_gate_response_checker.sv
// +-----------------------------------------------------------------+
// | tb_gate_response_checker : table-driven bench for the checker   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_gate_response_checker;
    import gate_check_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic in_a = 1'b0;
    logic in_b = 1'b0;
    logic in_y = 1'b0;

    logic        in_ready;
    logic [3:0]  cov;
    logic [7:0]  err_cnt;
    logic [15:0] vec_cnt;
    logic        first_fail_vld;
    logic [2:0]  first_fail;
    logic        done;
    logic        pass;

    logic        s_ready;
    logic [3:0]  s_cov;
    logic [1:0]  s_err;
    logic [15:0] s_vec;
    logic        s_ffv;
    logic [2:0]  s_ff;
    logic        s_done;
    logic        s_pass;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gate_response_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_y(in_y),
        .cov(cov), .err_cnt(err_cnt), .vec_cnt(vec_cnt),
        .first_fail_vld(first_fail_vld), .first_fail(first_fail),
        .done(done), .pass(pass)
    );

    gate_response_checker #(.TRUTH_TABLE(TT_AND), .ERR_W(2), .VEC_W(16)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(s_ready), .in_a(in_a), .in_b(in_b), .in_y(in_y),
        .cov(s_cov), .err_cnt(s_err), .vec_cnt(s_vec),
        .first_fail_vld(s_ffv), .first_fail(s_ff),
        .done(s_done), .pass(s_pass)
    );

    typedef struct {
        logic       st, v, a, b, y;
        logic       rdy;
        logic [3:0] cov;
        int         err;
        int         vec;
        logic       ffv;
        logic [2:0] ff;
        logic       dn, ps;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic v, logic a, logic b, logic y,
                                logic rdy, logic [3:0] c, int e, int n,
                                logic ffv, logic [2:0] ff, logic dn, logic ps);
        vec_t r;
        r.st = st; r.v = v; r.a = a; r.b = b; r.y = y;
        r.rdy = rdy; r.cov = c; r.err = e; r.vec = n;
        r.ffv = ffv; r.ff = ff; r.dn = dn; r.ps = ps;
        return r;
    endfunction

    function automatic logic [34:0] observed();
        return {in_ready, cov, err_cnt, vec_cnt, first_fail_vld, first_fail, done, pass};
    endfunction

    function automatic logic [34:0] expected(vec_t e);
        return {e.rdy, e.cov, 8'(e.err), 16'(e.vec), e.ffv, e.ff, e.dn, e.ps};
    endfunction

    task automatic check(string name, logic [34:0] got, logic [34:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (rdy,cov,err,vec,ffv,ff,done,pass)",
                     name, got, exp);
        end
    endtask

    task automatic check_s(string name, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(logic st, logic v, logic a, logic b, logic y);
        start = st; in_valid = v; in_a = a; in_b = b; in_y = y;
    endtask

    initial begin
        // Full NAND sweep, then a vector while DONE (ignored)
        tbl.push_back(mk(1,0,0,0,0, 1,4'h0,0,0, 0,3'b000,0,0));
        tbl.push_back(mk(0,1,0,0,1, 1,4'h1,0,1, 0,3'b000,0,0));
        tbl.push_back(mk(0,1,0,1,1, 1,4'h3,0,2, 0,3'b000,0,0));
        tbl.push_back(mk(0,1,1,0,1, 1,4'h7,0,3, 0,3'b000,0,0));
        tbl.push_back(mk(0,1,1,1,0, 0,4'hF,0,4, 0,3'b000,1,1));
        tbl.push_back(mk(0,1,0,0,0, 0,4'hF,0,4, 0,3'b000,1,1));
        // Restart from DONE, 11/1 injected second
        tbl.push_back(mk(1,0,0,0,0, 1,4'h0,0,0, 0,3'b000,0,0));
        tbl.push_back(mk(0,1,0,0,1, 1,4'h1,0,1, 0,3'b000,0,0));
        tbl.push_back(mk(0,1,1,1,1, 1,4'h9,1,2, 1,3'b111,0,0));
        tbl.push_back(mk(0,1,0,1,1, 1,4'hB,1,3, 1,3'b111,0,0));
        tbl.push_back(mk(0,1,1,0,1, 0,4'hF,1,4, 1,3'b111,1,0));
        // Repeats: 00/1 x3 then 01/0
        tbl.push_back(mk(1,0,0,0,0, 1,4'h0,0,0, 0,3'b000,0,0));
        tbl.push_back(mk(0,1,0,0,1, 1,4'h1,0,1, 0,3'b000,0,0));
        tbl.push_back(mk(0,1,0,0,1, 1,4'h1,0,2, 0,3'b000,0,0));
        tbl.push_back(mk(0,1,0,0,1, 1,4'h1,0,3, 0,3'b000,0,0));
        tbl.push_back(mk(0,1,0,1,0, 1,4'h3,1,4, 1,3'b010,0,0));
        // Start in RUN with a simultaneous handshake, then gappy traffic
        tbl.push_back(mk(1,1,1,0,1, 1,4'h0,0,0, 0,3'b000,0,0));
        tbl.push_back(mk(0,0,1,1,1, 1,4'h0,0,0, 0,3'b000,0,0));
        tbl.push_back(mk(0,1,1,0,0, 1,4'h4,1,1, 1,3'b100,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,4'h4,1,1, 1,3'b100,0,0));
        tbl.push_back(mk(0,0,0,1,0, 1,4'h4,1,1, 1,3'b100,0,0));
        tbl.push_back(mk(0,1,1,1,0, 1,4'hC,1,2, 1,3'b100,0,0));
        tbl.push_back(mk(0,1,1,1,1, 1,4'hC,2,3, 1,3'b100,0,0));

        // Reset state while rst_n is held low
        #12;
        check("reset", observed(), 35'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // IDLE ignores traffic
        drive(0, 1, 0, 0, 1);
        @(posedge clk); #1;
        check("idle_ignore", observed(), 35'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].y);
            @(posedge clk); #1;
            check($sformatf("rec%0d", i), observed(), expected(tbl[i]));
        end

        // Saturation on the 2-bit AND instance: 5 mismatching 00/1 vectors
        drive(1, 0, 0, 0, 0);
        @(posedge clk); #1;
        check_s("sat_clear", 16'(s_err), 16'd0);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 1, 0, 0, 1);
            @(posedge clk); #1;
            check_s($sformatf("sat_err%0d", k), 16'(s_err), (k < 3) ? 16'(k) : 16'd3);
        end
        check_s("sat_vec", s_vec, 16'd5);
        check_s("sat_ff", {13'd0, s_ff}, 16'd1);
        check_s("main_vec5", vec_cnt, 16'd5);

        // Asynchronous reset mid-RUN, between clock edges
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        check("async_rst", observed(), 35'd0);
        check_s("async_rst_sat", {14'd0, s_err}, 16'd0);
        #2;
        rst_n = 1'b1;
        drive(0, 1, 1, 1, 0);
        @(posedge clk); #1;
        check("post_rst_idle", observed(), 35'd0);
        drive(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
